// File: rtl/join2_pkg.sv
// Shared types and constants for the join2_sync block and its input FIFOs.
package join2_pkg;

  // Output register occupancy.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Per-channel buffering: one channel may run this many tokens ahead.
  localparam int FIFO_DEPTH = 2;

  // Width needed to hold an occupancy of 0..FIFO_DEPTH.
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  // Occupancy value at which a FIFO stops accepting.
  localparam logic [FIFO_CNT_W-1:0] FIFO_FULL = FIFO_CNT_W'(FIFO_DEPTH);

endpackage

// File: rtl/join2_sync_fifo.sv
// tok_fifo2: two-entry register FIFO holding tokens for one join input channel.
// Ready is registered from the next occupancy so it never depends on valid.
module tok_fifo2
  import join2_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_push_data,
  input  logic                  i_pop,
  output logic [FIFO_CNT_W-1:0] o_count,
  output logic [WIDTH-1:0]      o_head,
  output logic                  o_ready
);

  logic [WIDTH-1:0]      r_mem [FIFO_DEPTH];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [FIFO_CNT_W-1:0] r_count;
  logic                  r_ready;
  logic [FIFO_CNT_W-1:0] w_count_nxt;

  // Next occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_count_nxt = r_count;
    case ({i_push, i_pop})
      2'b10:   w_count_nxt = r_count + FIFO_CNT_W'(1);
      2'b01:   w_count_nxt = r_count - FIFO_CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointer, occupancy and ready registers; all cleared by reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < FIFO_FULL);
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; occupancy alone decides which entries are meaningful.
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_ready = r_ready;

endmodule

// File: rtl/join2_sync.sv
// join2_sync: joins one token from each of two valid/ready channels into a single
// output token {in1, in0} and flags whether the two payloads differed.
module join2_sync
  import join2_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in0_valid,
  output logic                 in0_ready,
  input  logic [WIDTH-1:0]     in0_data,
  input  logic                 in1_valid,
  output logic                 in1_ready,
  input  logic [WIDTH-1:0]     in1_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_data,
  output logic                 out_mismatch,
  output logic [CNT_W-1:0]     join_count,
  output logic [CNT_W-1:0]     mismatch_count
);

  out_state_t            r_state;
  out_state_t            w_state_nxt;
  logic [2*WIDTH-1:0]    r_data;
  logic                  r_mismatch;
  logic [CNT_W-1:0]      r_join_count;
  logic [CNT_W-1:0]      r_mismatch_count;

  logic                  w_push0, w_push1;
  logic [FIFO_CNT_W-1:0] w_count0, w_count1;
  logic [WIDTH-1:0]      w_head0, w_head1;
  logic                  w_ready0, w_ready1;
  logic                  w_fire;
  logic                  w_deliver;

  assign w_push0   = in0_valid && w_ready0;
  assign w_push1   = in1_valid && w_ready1;
  assign w_deliver = (r_state == OUT_FULL) && out_ready;
  assign w_fire    = (w_count0 != '0) && (w_count1 != '0) &&
                     ((r_state == OUT_EMPTY) || out_ready);

  tok_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push0),
    .i_push_data (in0_data),
    .i_pop       (w_fire),
    .o_count     (w_count0),
    .o_head      (w_head0),
    .o_ready     (w_ready0)
  );

  tok_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push1),
    .i_push_data (in1_data),
    .i_pop       (w_fire),
    .o_count     (w_count1),
    .o_head      (w_head1),
    .o_ready     (w_ready1)
  );

  // Output register next state: a join refills it, a delivery without a join drains it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      OUT_EMPTY: if (w_fire) w_state_nxt = OUT_FULL;
      OUT_FULL: begin
        if (w_fire)         w_state_nxt = OUT_FULL;
        else if (out_ready) w_state_nxt = OUT_EMPTY;
      end
      default:              w_state_nxt = OUT_EMPTY;
    endcase
  end

  // Output state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= OUT_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Joined payload and mismatch flag; held until the next join replaces them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data     <= '0;
      r_mismatch <= 1'b0;
    end else if (w_fire) begin
      r_data     <= {w_head1, w_head0};
      r_mismatch <= (w_head0 != w_head1);
    end
  end

  // Saturating delivery statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_join_count     <= '0;
      r_mismatch_count <= '0;
    end else if (w_deliver) begin
      if (r_join_count != '1)
        r_join_count <= r_join_count + CNT_W'(1);
      if (r_mismatch && (r_mismatch_count != '1))
        r_mismatch_count <= r_mismatch_count + CNT_W'(1);
    end
  end

  assign in0_ready      = w_ready0;
  assign in1_ready      = w_ready1;
  assign out_valid      = (r_state == OUT_FULL);
  assign out_data       = r_data;
  assign out_mismatch   = r_mismatch;
  assign join_count     = r_join_count;
  assign mismatch_count = r_mismatch_count;

endmodule

// File: tb/tb_join2_sync.sv
// Self-checking bench for join2_sync: a vector table for single-cycle joins plus
// directed sequences for skew, backpressure, mid-stream reset and saturation.
module tb_join2_sync;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               in0_valid, in0_ready;
  logic [WIDTH-1:0]   in0_data;
  logic               in1_valid, in1_ready;
  logic [WIDTH-1:0]   in1_data;
  logic               out_valid, out_ready;
  logic [2*WIDTH-1:0] out_data;
  logic               out_mismatch;
  logic [CNT_W-1:0]   join_count, mismatch_count;

  int n_checks = 0;
  int n_errors = 0;

  // Streaming stimulus state.
  logic [7:0] sa [32];
  logic [7:0] sb [32];
  int         n_tok, idx0, idx1;

  typedef struct {
    logic        v0;
    logic [7:0]  d0;
    logic        v1;
    logic [7:0]  d1;
    logic        ordy;
    logic        e_ov;
    logic [15:0] e_od;
    logic        e_mm;
    logic        e_r0;
    logic        e_r1;
    logic [3:0]  e_jc;
    logic [3:0]  e_mc;
  } vec_t;

  vec_t vecs [8];

  join2_sync #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .in0_valid      (in0_valid),
    .in0_ready      (in0_ready),
    .in0_data       (in0_data),
    .in1_valid      (in1_valid),
    .in1_ready      (in1_ready),
    .in1_data       (in1_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_mismatch   (out_mismatch),
    .join_count     (join_count),
    .mismatch_count (mismatch_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    in0_data  = '0;
    in1_data  = '0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // One cycle of streaming from sa/sb; indices advance only on a real handshake.
  task automatic stream_cycle();
    bit hs0, hs1;
    in0_valid = (idx0 < n_tok);
    in0_data  = (idx0 < n_tok) ? sa[idx0] : 8'h00;
    in1_valid = (idx1 < n_tok);
    in1_data  = (idx1 < n_tok) ? sb[idx1] : 8'h00;
    hs0 = in0_valid && in0_ready;
    hs1 = in1_valid && in1_ready;
    tick();
    if (hs0) idx0++;
    if (hs1) idx1++;
  endtask

  initial begin
    // Inputs, expected outputs after the edge.
    vecs[0] = '{1'b1, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 16'h5A5A, 1'b0, 1'b1, 1'b1, 4'd1, 4'd0};
    vecs[3] = '{1'b1, 8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 16'h5A5A, 1'b0, 1'b1, 1'b1, 4'd1, 4'd0};
    vecs[4] = '{1'b1, 8'h22, 1'b1, 8'h23, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b1, 1'b1, 4'd1, 4'd0};
    vecs[5] = '{1'b1, 8'h33, 1'b1, 8'h33, 1'b1, 1'b1, 16'h2322, 1'b1, 1'b1, 1'b1, 4'd2, 4'd0};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 16'h3333, 1'b0, 1'b1, 1'b1, 4'd3, 4'd1};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 16'h3333, 1'b0, 1'b1, 1'b1, 4'd4, 4'd1};

    // Reset held 3 cycles with both valids high.
    reset     = 1'b1;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 8'hAA;
    in1_data  = 8'hBB;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_in0_ready", in0_ready, 0);
      check("rst_in1_ready", in1_ready, 0);
      check("rst_out_valid", out_valid, 0);
    end
    check("rst_out_data", out_data, 0);
    check("rst_join_count", join_count, 0);
    check("rst_mis_count", mismatch_count, 0);
    reset     = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    tick();
    check("rel_in0_ready", in0_ready, 1);
    check("rel_in1_ready", in1_ready, 1);
    tick();
    check("rel_no_output", out_valid, 0);

    // Table: matched pair latency then back-to-back streaming.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in0_valid = vecs[i].v0;
      in0_data  = vecs[i].d0;
      in1_valid = vecs[i].v1;
      in1_data  = vecs[i].d1;
      out_ready = vecs[i].ordy;
      tick();
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
      check($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
      check($sformatf("vec%0d_mismatch", i), out_mismatch, vecs[i].e_mm);
      check($sformatf("vec%0d_in0_ready", i), in0_ready, vecs[i].e_r0);
      check($sformatf("vec%0d_in1_ready", i), in1_ready, vecs[i].e_r1);
      check($sformatf("vec%0d_join_count", i), join_count, vecs[i].e_jc);
      check($sformatf("vec%0d_mis_count", i), mismatch_count, vecs[i].e_mc);
    end

    // Skew: in0 runs two tokens ahead and stalls, then in1 catches up.
    do_reset();
    in0_valid = 1'b1; in0_data = 8'h01; tick();
    check("skew_ready_after1", in0_ready, 1);
    in0_data = 8'h02; tick();
    check("skew_ready_after2", in0_ready, 0);
    in0_data = 8'h03; tick();
    check("skew_stall_ready", in0_ready, 0);
    check("skew_stall_valid", out_valid, 0);
    in1_valid = 1'b1; in1_data = 8'h01; tick();
    check("skew_in1_push_ready0", in0_ready, 0);
    check("skew_in1_push_valid", out_valid, 0);
    in1_data = 8'h07; tick();
    check("skew_out0_valid", out_valid, 1);
    check("skew_out0_data", out_data, 16'h0101);
    check("skew_out0_mm", out_mismatch, 0);
    check("skew_in0_ready_back", in0_ready, 1);
    in1_data = 8'h03; tick();
    check("skew_out1_data", out_data, 16'h0702);
    check("skew_out1_mm", out_mismatch, 1);
    in0_valid = 1'b0; in1_valid = 1'b0; tick();
    check("skew_out2_data", out_data, 16'h0303);
    check("skew_out2_mm", out_mismatch, 0);
    tick();
    check("skew_drained", out_valid, 0);
    check("skew_join_count", join_count, 3);
    check("skew_mis_count", mismatch_count, 1);

    // Backpressure: out_ready low 5 cycles while both inputs stream.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sa[i] = 8'h40 + 8'(i);
      sb[i] = 8'h40 + 8'(i);
    end
    n_tok = 6; idx0 = 0; idx1 = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      stream_cycle();
      if (c >= 1) begin
        check($sformatf("bp_hold_valid_c%0d", c), out_valid, 1);
        check($sformatf("bp_hold_data_c%0d", c), out_data, {sb[0], sa[0]});
      end
    end
    check("bp_in0_ready_low", in0_ready, 0);
    check("bp_in1_ready_low", in1_ready, 0);
    check("bp_in0_accepted", idx0, 3);
    check("bp_in1_accepted", idx1, 3);
    out_ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      stream_cycle();
      check($sformatf("bp_rel_valid_%0d", k), out_valid, 1);
      check($sformatf("bp_rel_data_%0d", k), out_data, {sb[k], sa[k]});
      check($sformatf("bp_rel_count_%0d", k), join_count, k);
    end
    stream_cycle();
    check("bp_end_valid", out_valid, 0);
    check("bp_end_join_count", join_count, 6);
    check("bp_end_mis_count", mismatch_count, 0);

    // Reset mid-stream with tokens buffered on both sides and the output full.
    for (int i = 0; i < 6; i++) begin
      sa[i] = 8'hC0 + 8'(i);
      sb[i] = 8'hD0 + 8'(i);
    end
    idx0 = 0; idx1 = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) stream_cycle();
    check("mid_pre_valid", out_valid, 1);
    check("mid_pre_in0_ready", in0_ready, 0);
    check("mid_pre_in1_ready", in1_ready, 0);
    reset = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_mm", out_mismatch, 0);
    check("mid_rst_join_count", join_count, 0);
    check("mid_rst_mis_count", mismatch_count, 0);
    check("mid_rst_in0_ready", in0_ready, 0);
    check("mid_rst_in1_ready", in1_ready, 0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("mid_after_valid_c%0d", c), out_valid, 0);
    end
    check("mid_after_join_count", join_count, 0);

    // Saturation: 20 mismatched joins into 4-bit counters.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      sa[i] = 8'(i);
      sb[i] = 8'(i) ^ 8'hFF;
    end
    n_tok = 20; idx0 = 0; idx1 = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) stream_cycle();
    check("sat_all_accepted", idx0, 20);
    check("sat_join_count", join_count, 15);
    check("sat_mis_count", mismatch_count, 15);
    check("sat_last_data", out_data, {8'(19) ^ 8'hFF, 8'(19)});
    check("sat_drained", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/join2_sync.md
Name: join2_sync

Overview:
- Clocked, synthesizable 2-to-1 synchronizing join; the receiving counterpart of the copy2 fork.
- Takes one token from each of two valid/ready input channels and emits a single combined token carrying both payloads.
- Flags when the two payloads differ, so it can recombine and cross-check the duplicated streams a fork produces.
- Sits downstream of a fork stage and upstream of a single consumer.

Parameters:
WIDTH, 8, payload width of each input channel
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in0_valid  input  1  channel 0 token present
in0_ready  output  1  channel 0 can accept (registered)
in0_data  input  WIDTH  channel 0 payload
in1_valid  input  1  channel 1 token present
in1_ready  output  1  channel 1 can accept (registered)
in1_data  input  WIDTH  channel 1 payload
out_valid  output  1  joined token present
out_ready  input  1  consumer accepts joined token
out_data  output  2*WIDTH  {in1 payload, in0 payload}
out_mismatch  output  1  joined token's payloads differed
join_count  output  CNT_W  joined tokens delivered (out_valid && out_ready), saturating
mismatch_count  output  CNT_W  delivered tokens with out_mismatch=1, saturating

Behaviour:
- Reset (sampled at clk edge while reset=1):
  - Both FIFOs and the output register are emptied.
  - out_valid=0, out_data=0, out_mismatch=0.
  - join_count=0, mismatch_count=0.
  - in0_ready=in1_ready=0 while reset is high; both go to 1 in the first cycle after reset deasserts.
- Reset mid-operation discards all buffered tokens; no partial output is emitted.
- Input side:
  - Each channel has an independent 2-entry FIFO (tok_fifo2).
  - A handshake occurs when inX_valid && inX_ready at a clock edge; inX_data is written on that edge.
  - inX_ready = FIFO count < 2, registered from count only; there is no combinational valid-to-ready path.
  - Data must be held while valid is high and ready is low. The block never drops a token.
- Join condition (combinational, evaluated each cycle):
  - fire = both FIFOs non-empty && (out register empty || out_ready).
  - On fire, both FIFO heads pop and the output register loads:
    - out_data = {head1, head0}
    - out_mismatch = (head0 != head1)
- Output register FSM (states in package):
  - OUT_EMPTY -> OUT_FULL on fire.
  - OUT_FULL -> OUT_FULL on fire with out_ready (back-to-back replacement).
  - OUT_FULL -> OUT_EMPTY on out_ready without fire.
  - OUT_FULL holds when out_ready=0.
  - out_valid = (state == OUT_FULL). out_data is stable while out_valid && !out_ready.
- Latency: minimum 2 edges from the later of the two input handshakes to out_valid=1.
- Throughput: 1 join/cycle sustained when both inputs stream and out_ready=1.
- Simultaneous push and pop on a FIFO in the same edge: count unchanged, ready stays 1.
- Skew: one channel may run up to 2 tokens ahead of the other. It then stalls (ready=0) until the other side supplies a token; no reordering.
- Counters:
  - Increment on the delivery edge (out_valid && out_ready).
  - Saturate at 2^CNT_W-1 with no wrap.
  - mismatch_count increments only if out_mismatch=1 for the delivered token.

Decomposition:
- Package join2_pkg holds:
  - typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t
  - the FIFO depth constant FIFO_DEPTH=2
  - the count-width localparam derived from it
- Sub-module tok_fifo2:
  - Parameterized by WIDTH; 2-entry register FIFO with push/pop/count/head ports and the same clk/reset.
  - Instantiated once per input channel.
- Join logic, output FSM and counters stay in join2_sync.

Test Plan:
- Reset: hold reset 3 cycles with both valids high -> no handshake, out_valid=0, counters 0; ready=1 the first cycle after release.
- Matched pair: in0=0x5A at cycle 2, in1=0x5A at cycle 2, out_ready=1 -> out_valid at cycle 4, out_data=0x5A5A, out_mismatch=0, join_count=1, mismatch_count=0.
- Mismatch and skew: in0 sends 0x01,0x02,0x03 back-to-back, in1 idle -> in0_ready drops to 0 after 2 accepts; then in1 sends 0x01,0x07,0x03 -> outputs 0x0101, 0x0702 (mismatch=1), 0x0303 in order; mismatch_count=1.
- Backpressure: out_ready=0 for 5 cycles with both inputs streaming -> out_data held stable, both FIFOs fill, both readies go to 0; release -> 1 token per cycle, join_count advances by 1 each cycle, no loss.
- Reset mid-stream: assert reset with 2 tokens buffered per side and out_valid=1 -> next cycle all outputs 0, and the buffered tokens are never emitted.
- Saturation (CNT_W=4): deliver 20 mismatched joins -> join_count and mismatch_count both stop at 15.
